mod_counter_dff: RTL
====================

// Module: mod_counter_dff
// PURPOSE
//   Loadable up/down modulo-N counter built on the team's edge-triggered D flip-flop.
//   One flop per state bit. Next-state logic is gate-level (and/or/not/nand).
//   Consumes the flop stage directly: feeds its q outputs back through next-state logic.
//   Provides a terminal-count pulse so counters can be cascaded (BCD digits, dividers).
// PARAMETERS
//   WIDTH    4   state width in bits; legal range 2..8
//   MODULUS  10  count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
// PORTS
//   c    input   1      clock; all state updates on rising edge
//   re_  input   1      reset, asynchronous, active-low
//   en   input   1      count enable
//   up   input   1      direction: 1 = increment, 0 = decrement
//   ld   input   1      synchronous parallel load
//   din  input   WIDTH  load value
//   q    output  WIDTH  current count
//   tc   output  1      terminal count (combinational, cascade carry/borrow)
// BEHAVIOUR
//   Reset:
//     - re_=0 forces q=0 immediately, independent of c; held while re_=0.
//     - tc follows its equation from q=0: tc = en & ~up during reset.
//     - Release of re_ is effective on the next rising edge of c.
//     - Reset mid-count discards the count; no partial update.
//   Priority at each rising edge of c (re_=1):
//     - ld=1             -> q <= (din < MODULUS) ? din : 0   (out-of-range load clears)
//     - ld=0, en=1, up=1 -> q <= (q == MODULUS-1) ? 0 : q+1
//     - ld=0, en=1, up=0 -> q <= (q == 0) ? MODULUS-1 : q-1
//     - ld=0, en=0       -> q holds
//   ld overrides en and up in the same cycle; the loaded value is not also counted.
//   Illegal states (q >= MODULUS, only reachable via glitch or X):
//     - next count edge forces q to 0 in either direction.
//   tc = en & ((up & q==MODULUS-1) | (~up & q==0)); purely combinational, no latency.
//   Latency:
//     - ld/en/up sampled at edge N; q updated after edge N.
//     - tc reflects the new q in the same cycle.
//   Arithmetic:
//     - WIDTH-bit ripple incrementer/decrementer from gate primitives.
//     - Wrap uses compare-to-constant, never natural 2**WIDTH overflow
//       (except MODULUS == 2**WIDTH, where both coincide).
//   Cascading: a higher digit's en is driven by the lower digit's tc; no extra logic.
//   Direction change: takes effect on the next enabled edge; no pipeline state to flush.
// TESTING
//   1. Reset: re_=0 mid-count at q=7, no clock -> q=0 within the same time step;
//      tc=1 if en=1,up=0, else 0.
//   2. Up wrap (M=10): en=1,up=1 from 0, 12 edges -> q: 1..9,0,1,2;
//      tc=1 only while q=9.
//   3. Down wrap (M=10): en=1,up=0 from 0 -> q=9,8,...;
//      tc=1 while q=0, 0 elsewhere.
//   4. Load priority: q=3, ld=1,en=1,up=1,din=6 -> q=6 (not 7);
//      din=12 -> q=0; ld=1,en=0 -> load still occurs.
//   5. Hold/direction: en=0 for 5 edges at q=4 -> q=4, tc=0;
//      then toggle up each edge -> q=5,4,5,4.
//   6. Cascade: two instances (M=10), high.en=low.tc, count up 100 edges
//      -> {high,low}=00..99 then 00; high.tc=1 only at 99.
//   Repeat tests 2-3 with WIDTH=3, MODULUS=8 (natural wrap) and MODULUS=5.

Source files
------------

// File: rtl/mod_counter_dff_if.sv
// Control and status bundle for mod_counter_dff: enable, direction, load, count, terminal count.
interface mod_counter_dff_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             ld;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (output en, output up, output ld, output din, input q, input tc);
    modport slave  (input en, input up, input ld, input din, output q, output tc);
endinterface

// File: rtl/mod_counter_dff.sv
// Loadable up/down modulo-MODULUS counter: one D flop per bit, gate-level next-state logic,
// combinational terminal count for cascading.
module mod_counter_dff #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input logic              c,
    input logic              re_,
    mod_counter_dff_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 8 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("mod_counter_dff: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH:0]   K_MOD = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] K_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_up_val;
    logic [WIDTH-1:0] w_dn_val;
    logic [WIDTH-1:0] w_ld_val;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_illegal;
    logic             w_din_ok;
    logic             w_sel_ld;
    logic             w_sel_up;
    logic             w_sel_dn;
    logic             w_sel_hold;

    // Equality against a constant: AND of per-bit XNORs.
    function automatic logic f_eq_const(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] k);
        logic v_eq;
        v_eq = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            v_eq = v_eq & ((k[i] & a[i]) | (~k[i] & ~a[i]));
        end
        return v_eq;
    endfunction

    // a >= MODULUS, rippled LSB to MSB; never true when MODULUS == 2**WIDTH.
    function automatic logic f_ge_mod(input logic [WIDTH-1:0] a);
        logic v_ge;
        v_ge = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            v_ge = (K_MOD[i] & a[i] & v_ge) | (~K_MOD[i] & (a[i] | v_ge));
        end
        return v_ge & ~K_MOD[WIDTH];
    endfunction

    always_comb begin : p_arith
        logic v_carry;
        logic v_borrow;
        v_carry  = 1'b1;
        v_borrow = 1'b1;
        w_inc    = '0;
        w_dec    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_inc[i] = (w_q[i] & ~v_carry) | (~w_q[i] & v_carry);
            w_dec[i] = (w_q[i] & ~v_borrow) | (~w_q[i] & v_borrow);
            v_carry  = w_q[i] & v_carry;
            v_borrow = ~w_q[i] & v_borrow;
        end
    end

    assign w_at_max  = f_eq_const(w_q, K_MAX);
    assign w_at_zero = f_eq_const(w_q, '0);
    assign w_illegal = f_ge_mod(w_q);
    assign w_din_ok  = ~f_ge_mod(bus.din);

    assign w_sel_ld   = bus.ld;
    assign w_sel_up   = ~bus.ld & bus.en & bus.up;
    assign w_sel_dn   = ~bus.ld & bus.en & ~bus.up;
    assign w_sel_hold = ~bus.ld & ~bus.en;

    // Wrap is by compare-to-constant; an illegal state counts to zero in either direction.
    assign w_ld_val = bus.din & {WIDTH{w_din_ok}};
    assign w_up_val = w_inc & ~{WIDTH{w_at_max | w_illegal}};
    assign w_dn_val = (w_dec & ~{WIDTH{w_at_zero | w_illegal}})
                    | (K_MAX & {WIDTH{w_at_zero & ~w_illegal}});

    assign w_d = ({WIDTH{w_sel_ld}}   & w_ld_val)
               | ({WIDTH{w_sel_up}}   & w_up_val)
               | ({WIDTH{w_sel_dn}}   & w_dn_val)
               | ({WIDTH{w_sel_hold}} & w_q);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic r_bit;
        always_ff @(posedge c or negedge re_) begin
            if (!re_) begin
                r_bit <= 1'b0;
            end else begin
                r_bit <= w_d[gi];
            end
        end
        assign w_q[gi] = r_bit;
    end

    assign bus.q  = w_q;
    assign bus.tc = bus.en & ((bus.up & w_at_max) | (~bus.up & w_at_zero));

endmodule
